// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit DFF register (q/q_) among NREQ requesters; grant 1 cycle after req.
// Requesters wait on gnt; release hands over back-to-back. HOLD_LIMIT_EN caps a tenure at MAX_HOLD cycles.
module dff_bank_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16,
  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         we,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic [IDX_W-1:0]        owner,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        q_
);

  if ((NREQ < 1) || (NREQ > 16)) begin : g_bad_nreq
    $error("dff_bank_arbiter: NREQ must be 1..16");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("dff_bank_arbiter: MAX_HOLD must be >= 2");
  end

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NREQ-1:0]      r_gnt;
  logic [NREQ-1:0]      w_gnt_nxt;
  logic                 r_busy;
  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     w_owner_nxt;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic [IDX_W-1:0]     w_ptr_inc;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_qn;
  logic [WIDTH-1:0]     w_q_nxt;
  logic [NREQ-1:0]      w_owner_oh;
  logic [NREQ-1:0]      w_mask;
  logic [IDX_W:0]       w_pick;
  logic                 w_own_req;
  logic                 w_force;
  logic                 w_new_grant;

  // Returns {found, index} of the first set bit scanning base, base+1, ... mod NREQ.
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDX_W-1:0] base);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(base) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (r[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign w_own_req = req[r_owner];
  assign w_ptr_inc = (r_owner == IDX_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);

  logic [CNT_W-1:0] r_hold_cnt;

  assign w_force = (r_state == ST_BUSY) && w_own_req &&
                   (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (w_new_grant) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_BUSY) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_new_grant = 1'b0;
    w_owner_oh  = onehot(r_owner);
    w_mask      = req;
    w_pick      = rr_pick(req, r_ptr);

    case (r_state)
      ST_IDLE: begin
        if (w_pick[IDX_W]) begin
          w_gnt_nxt   = onehot(w_pick[IDX_W-1:0]);
          w_owner_nxt = w_pick[IDX_W-1:0];
          w_new_grant = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!w_own_req || w_force) begin
          // Owner is excluded from this one decision; a voluntary release already has it at 0.
          w_ptr_nxt = w_ptr_inc;
          w_mask    = req & ~w_owner_oh;
          w_pick    = rr_pick(w_mask, w_ptr_inc);
          if (w_pick[IDX_W]) begin
            w_gnt_nxt   = onehot(w_pick[IDX_W-1:0]);
            w_owner_nxt = w_pick[IDX_W-1:0];
            w_new_grant = 1'b1;
          end else if (w_force) begin
            w_gnt_nxt   = w_owner_oh;
            w_new_grant = 1'b1;
          end else begin
            w_gnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write port follows the grant as registered, so the releasing owner still writes.
  always_comb begin
    w_q_nxt = r_q;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i] && we[i]) w_q_nxt = wdata[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_q     <= '0;
      r_qn    <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= |w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_q     <= w_q_nxt;
      r_qn    <= ~w_q_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign busy  = r_busy;
  assign owner = r_owner;
  assign q     = r_q;
  assign q_    = r_qn;

endmodule
